// File: rtl/seq_shared_reg_pkg.sv
// Shared types for the sequential shared-register arbiter.
// Optional build macro: SEQ_SHARED_REG_SATURATE_EN (see seq_shared_reg_arbiter).
package seq_shared_reg_pkg;

    // Operation applied to the shared register by the granted requester
    typedef enum logic [1:0] {
        CLR  = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        LOAD = 2'd3
    } op_t;

    // Arbiter state: free round-robin or held by a locked owner
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/seq_rr_pick.sv
// Combinational rotate-priority picker: one-hot grant for the first set
// request bit scanning upward from i_ptr, wrapping modulo N_REQ.
module seq_rr_pick #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_idx,
    output logic                     o_valid
);

    localparam int unsigned PW = $clog2(N_REQ);

    int unsigned w_pos;

    // Walk the requests starting at the pointer and keep the first hit
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_pos = 32'(i_ptr) + k;
            if (w_pos >= N_REQ) begin
                w_pos = w_pos - N_REQ;
            end
            if (!o_valid && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = PW'(w_pos);
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register
// (clear / increment / decrement / load) with bounded ownership lock.
// Build macro SEQ_SHARED_REG_SATURATE_EN: INC/DEC clamp at the limits
// instead of wrapping; ovf pulses on each clamped op. Arbitration unchanged.
module seq_shared_reg_arbiter
    import seq_shared_reg_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         lock,
    input  logic [2*N_REQ-1:0]       op,
    input  logic [N_REQ*WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic [WIDTH-1:0]         q,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     ovf
);

    localparam int unsigned PW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(MAX_LOCK + 1);

    arb_state_t       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_owner;
    logic [CW-1:0]    r_lock_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_valid;

    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_gidx;
    logic             w_gvalid;
    op_t              w_op;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_ovf_nxt;

    // Successor index modulo N_REQ
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] i_idx);
        if (32'(i_idx) == N_REQ - 1) begin
            return '0;
        end
        return i_idx + 1'b1;
    endfunction

    seq_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Grant: masked in reset, round-robin when idle, owner-only when locked
    always_comb begin
        w_gnt    = '0;
        w_gidx   = r_owner;
        w_gvalid = 1'b0;
        if (!rst_n) begin
            w_gnt = '0;
        end else if (r_state == IDLE) begin
            w_gnt    = w_pick_gnt;
            w_gidx   = w_pick_idx;
            w_gvalid = w_pick_valid;
        end else if (req[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            w_gidx         = r_owner;
            w_gvalid       = 1'b1;
        end
    end

    assign gnt = w_gnt;

    // Select op and load data of the single granted requester
    always_comb begin
        w_op = CLR;
        w_wd = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_op = op_t'(op[2*i +: 2]);
                w_wd = wdata[WIDTH*i +: WIDTH];
            end
        end
    end

    // Next register value and overflow flag for the granted op
    always_comb begin
        w_q_nxt   = r_q;
        w_ovf_nxt = 1'b0;
        if (w_gvalid) begin
            case (w_op)
                CLR:  w_q_nxt = '0;
                INC: begin
                    if (&r_q) begin
                        w_ovf_nxt = 1'b1;
`ifdef SEQ_SHARED_REG_SATURATE_EN
                        w_q_nxt   = r_q;
`else
                        w_q_nxt   = '0;
`endif
                    end else begin
                        w_q_nxt = r_q + 1'b1;
                    end
                end
                DEC: begin
                    if (r_q == '0) begin
                        w_ovf_nxt = 1'b1;
`ifdef SEQ_SHARED_REG_SATURATE_EN
                        w_q_nxt   = '0;
`else
                        w_q_nxt   = '1;
`endif
                    end else begin
                        w_q_nxt = r_q - 1'b1;
                    end
                end
                LOAD: w_q_nxt = w_wd;
            endcase
        end
    end

    // FSM, lock counter, pointer and shared register update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_lock_cnt <= '0;
            r_q        <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_q   <= w_q_nxt;
            r_ovf <= w_ovf_nxt;
            case (r_state)
                IDLE: begin
                    if (w_gvalid) begin
                        r_owner <= w_gidx;
                        // A one-cycle cap is already exhausted by this grant
                        if (lock[w_gidx] && (MAX_LOCK > 1)) begin
                            r_state    <= LOCKED;
                            r_lock_cnt <= CW'(1);
                        end else begin
                            r_ptr <= f_next(w_gidx);
                        end
                    end
                end
                LOCKED: begin
                    if (!w_gvalid || !lock[r_owner] ||
                        (r_lock_cnt == CW'(MAX_LOCK - 1))) begin
                        r_state    <= IDLE;
                        r_lock_cnt <= '0;
                        r_ptr      <= f_next(r_owner);
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign q     = r_q;
    assign owner = r_owner;
    assign ovf   = r_ovf;

endmodule
